mem_access: RTL and testbench

- MEM-stage consumer of the EX/MEM pipeline-register outputs.
- Turns the registered address, aluop and store data into a req/gnt/rvalid data-memory transaction.
- Formats load data (byte/half extract, sign/zero extend) and drives the MEM/WB write-back fields.
- Holds the pipeline via stall_req until the transaction completes.

---
 rtl/mem_access_pkg.sv | 68 ++++++
 rtl/mem_access_if.sv | 26 ++
 rtl/mem_load_fmt.sv | 39 +++
 rtl/mem_access.sv | 164 ++++++++++++++++
 tb/tb_mem_access.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the MEM-stage data-memory access block.
// Aluop codes of the eight memory operations, FSM state encodings,
// access-size classification and byte-lane select constants.
package mem_access_pkg;

    localparam int unsigned OP_W = 8;

    // Memory aluop encodings (must match the decoder's AluOpBus values)
    localparam logic [OP_W-1:0] OP_LB  = 8'h20;
    localparam logic [OP_W-1:0] OP_LH  = 8'h21;
    localparam logic [OP_W-1:0] OP_LW  = 8'h23;
    localparam logic [OP_W-1:0] OP_LBU = 8'h24;
    localparam logic [OP_W-1:0] OP_LHU = 8'h25;
    localparam logic [OP_W-1:0] OP_SB  = 8'h28;
    localparam logic [OP_W-1:0] OP_SH  = 8'h29;
    localparam logic [OP_W-1:0] OP_SW  = 8'h2b;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Byte-lane enables; a byte access shifts BE_BYTE0 by the address offset
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    function automatic logic op_is_load(input logic [OP_W-1:0] op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
               (op == OP_LBU) || (op == OP_LHU);
    endfunction

    function automatic logic op_is_store(input logic [OP_W-1:0] op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic op_is_mem(input logic [OP_W-1:0] op);
        return op_is_load(op) || op_is_store(op);
    endfunction

    function automatic acc_size_t op_size(input logic [OP_W-1:0] op);
        if ((op == OP_LB) || (op == OP_LBU) || (op == OP_SB))
            return SZ_BYTE;
        else if ((op == OP_LH) || (op == OP_LHU) || (op == OP_SH))
            return SZ_HALF;
        else
            return SZ_WORD;
    endfunction

    // True when the low address bits are not a multiple of the access size
    function automatic logic op_misaligned(input logic [OP_W-1:0] op, input logic [1:0] lo);
        case (op_size(op))
            SZ_HALF: return lo[0];
            SZ_WORD: return lo != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_if.sv
// Data-memory request bus: req/gnt address phase, rvalid/rdata response phase.
// Latency: none (wires only).
// Backpressure: master holds req and its payload until the slave raises gnt.
// Ports: master drives req/we/addr/wdata/be; slave drives gnt/rvalid/rdata.
interface mem_access_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      be;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/mem_load_fmt.sv
// Load data formatter: picks the byte/half lane and sign- or zero-extends it.
// Latency: combinational.
// Backpressure: none.
// Ports: rdata (raw word), addr_lo (byte offset), aluop (load kind) -> data.
module mem_load_fmt
    import mem_access_pkg::*;
#(
    parameter int ALUOP_W = 8,
    parameter int XLEN    = 32
) (
    input  logic [XLEN-1:0]    rdata,
    input  logic [1:0]         addr_lo,
    input  logic [ALUOP_W-1:0] aluop,
    output logic [XLEN-1:0]    data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        // addr_lo[0] is ignored for halves: misaligned halves are forced aligned
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (aluop)
            OP_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            OP_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
            OP_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
            OP_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM stage: turns EX/MEM memory ops into a req/gnt/rvalid transaction, formats loads, drives MEM/WB.
// Latency: non-memory ops pass through combinationally; stores >=3 cycles, loads 3 (same-cycle rvalid) or >=4.
// Backpressure: stall_req holds the upstream pipeline until gnt (and rvalid for loads); waits are unbounded.
// Ports: clk, rst_n; EX/MEM inputs mem_*; MEM/WB outputs wb_*; stall_req; dmem (mem_access_if master).
// Option: define MEM_MISALIGN_TRAP_EN to trap misaligned halves/words on excp_misalign instead of forcing alignment.
module mem_access
    import mem_access_pkg::*;
#(
    parameter int ALUOP_W = 8,
    parameter int XLEN    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [4:0]         mem_waddr,
    input  logic               mem_we,
    input  logic [XLEN-1:0]    mem_wdata,
    input  logic [XLEN-1:0]    mem_mem_addr,
    input  logic [ALUOP_W-1:0] mem_mem_aluop,
    input  logic [XLEN-1:0]    mem_rt_data,
    output logic [4:0]         wb_waddr,
    output logic               wb_we,
    output logic [XLEN-1:0]    wb_wdata,
    output logic               stall_req,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic               excp_misalign,
`endif
    mem_access_if.master       dmem
);

    state_t             state;
    logic               is_mem;
    logic               is_ld;
    logic               misalign;
    logic               start;
    logic [3:0]         be_n;
    logic [XLEN-1:0]    wdata_n;
    logic               ld_q;
    logic [1:0]         alo_q;
    logic [ALUOP_W-1:0] op_q;
    logic [XLEN-1:0]    ld_data_q;
    logic [XLEN-1:0]    fmt_data;

    always_comb begin
        is_mem   = op_is_mem(mem_mem_aluop);
        is_ld    = op_is_load(mem_mem_aluop);
        misalign = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign = is_mem && op_misaligned(mem_mem_aluop, mem_mem_addr[1:0]);
`endif
        start    = is_mem && !misalign;
    end

    // Lane-replicated store data so the memory only needs the byte enables
    always_comb begin
        be_n    = BE_WORD;
        wdata_n = mem_rt_data;
        case (op_size(mem_mem_aluop))
            SZ_BYTE: begin
                be_n    = BE_BYTE0 << mem_mem_addr[1:0];
                wdata_n = {4{mem_rt_data[7:0]}};
            end
            SZ_HALF: begin
                be_n    = mem_mem_addr[1] ? BE_HALF_HI : BE_HALF_LO;
                wdata_n = {2{mem_rt_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Formatting uses the offset/op latched at issue, not the live EX/MEM fields
    mem_load_fmt #(
        .ALUOP_W (ALUOP_W),
        .XLEN    (XLEN)
    ) u_load_fmt (
        .rdata   (dmem.rdata),
        .addr_lo (alo_q),
        .aluop   (op_q),
        .data    (fmt_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dmem.req   <= 1'b0;
            dmem.we    <= 1'b0;
            dmem.be    <= '0;
            dmem.addr  <= '0;
            dmem.wdata <= '0;
            ld_q       <= 1'b0;
            alo_q      <= 2'b00;
            op_q       <= '0;
            ld_data_q  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        dmem.req   <= 1'b1;
                        dmem.we    <= !is_ld;
                        dmem.be    <= be_n;
                        dmem.addr  <= {mem_mem_addr[XLEN-1:2], 2'b00};
                        dmem.wdata <= wdata_n;
                        ld_q       <= is_ld;
                        alo_q      <= mem_mem_addr[1:0];
                        op_q       <= mem_mem_aluop;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (dmem.gnt) begin
                        dmem.req <= 1'b0;
                        if (!ld_q) begin
                            state <= ST_DONE;
                        end else if (dmem.rvalid) begin
                            // zero-latency memory: data arrives with the grant
                            ld_data_q <= fmt_data;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dmem.rvalid) begin
                        ld_data_q <= fmt_data;
                        state     <= ST_DONE;
                    end
                end
                default: begin
                    // DONE: pipeline advances on this edge, so never re-issue
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Write-back fields; memory ops write back only in DONE, otherwise a bubble
    always_comb begin
        wb_waddr  = mem_waddr;
        wb_we     = mem_we;
        wb_wdata  = mem_wdata;
        stall_req = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        excp_misalign = 1'b0;
`endif
        if (!rst_n) begin
            wb_waddr = '0;
            wb_we    = 1'b0;
            wb_wdata = '0;
        end else if (state == ST_DONE) begin
            if (ld_q) wb_wdata = ld_data_q;
            else      wb_we    = 1'b0;
        end else if (state != ST_IDLE) begin
            wb_we     = 1'b0;
            stall_req = 1'b1;
        end else if (is_mem) begin
            wb_we     = 1'b0;
            stall_req = start;
`ifdef MEM_MISALIGN_TRAP_EN
            excp_misalign = misalign;
`endif
        end
    end

endmodule

// File: tb/tb_mem_access.sv
// Testbench for mem_access: scoreboarded bus requests and write-backs, reset cases, random ops.
// Latency: drives at negedge+1, samples at negedge+1 each cycle.
// Backpressure: memory responder inserts configurable gnt and rvalid delays.
module tb_mem_access;
    import mem_access_pkg::*;

    localparam logic [7:0] OP_ADD_TB = 8'h10;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic [7:0]  stall;
        logic [7:0]  reqs;
        logic        excp;
    } wb_exp_t;

    logic        clk;
    logic        rst_n;
    logic [4:0]  mem_waddr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_mem_addr;
    logic [7:0]  mem_mem_aluop;
    logic [31:0] mem_rt_data;
    logic [4:0]  wb_waddr;
    logic        wb_we;
    logic [31:0] wb_wdata;
    logic        stall_req;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        excp_misalign;
`endif

    mem_access_if #(.XLEN(32)) dmem_bus ();

    mem_access #(.ALUOP_W(8), .XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mem_waddr     (mem_waddr),
        .mem_we        (mem_we),
        .mem_wdata     (mem_wdata),
        .mem_mem_addr  (mem_mem_addr),
        .mem_mem_aluop (mem_mem_aluop),
        .mem_rt_data   (mem_rt_data),
        .wb_waddr      (wb_waddr),
        .wb_we         (wb_we),
        .wb_wdata      (wb_wdata),
        .stall_req     (stall_req),
`ifdef MEM_MISALIGN_TRAP_EN
        .excp_misalign (excp_misalign),
`endif
        .dmem          (dmem_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_pass;
    bus_exp_t bus_q[$];
    wb_exp_t  wb_q[$];

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic tb_is_ld(input logic [7:0] op);
        return op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU;
    endfunction

    function automatic logic tb_is_st(input logic [7:0] op);
        return op == OP_SB || op == OP_SH || op == OP_SW;
    endfunction

    function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [1:0] a, input logic [31:0] rd);
        logic [31:0] sh;
        case (op)
            OP_LB:   begin sh = rd >> (8 * a);    return {{24{sh[7]}}, sh[7:0]}; end
            OP_LBU:  begin sh = rd >> (8 * a);    return {24'h0, sh[7:0]}; end
            OP_LH:   begin sh = rd >> (16 * a[1]); return {{16{sh[15]}}, sh[15:0]}; end
            OP_LHU:  begin sh = rd >> (16 * a[1]); return {16'h0, sh[15:0]}; end
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] exp_be(input logic [7:0] op, input logic [1:0] a);
        if (op == OP_SB) return 4'b0001 << a;
        if (op == OP_SH) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] exp_wdat(input logic [7:0] op, input logic [31:0] rt);
        if (op == OP_SB) return {4{rt[7:0]}};
        if (op == OP_SH) return {2{rt[15:0]}};
        return rt;
    endfunction

    // Called at negedge+1; returns at negedge+1 with the DUT back in IDLE.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] rt, input logic [31:0] alu, input logic [4:0] wa,
                          input logic we, input int gdly, input int rdly, input logic [31:0] rdata);
        bus_exp_t pb, eb;
        wb_exp_t  ew, gw;
        logic mem, ld, mis, granted, done;
        int req_seen, since, stall_n;
        mem = tb_is_ld(op) || tb_is_st(op);
        ld  = tb_is_ld(op);
        mis = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        if (op == OP_LH || op == OP_LHU || op == OP_SH) mis = addr[0];
        if (op == OP_LW || op == OP_SW) mis = addr[1:0] != 2'b00;
`endif
        if (mem && !mis) begin
            pb.we    = tb_is_st(op);
            pb.addr  = addr & 32'hFFFF_FFFC;
            pb.be    = exp_be(op, addr[1:0]);
            pb.wdata = exp_wdat(op, rt);
            bus_q.push_back(pb);
        end
        ew.we    = !mem ? we : ((mis || !ld) ? 1'b0 : we);
        ew.waddr = wa;
        ew.wdata = (mem && ld) ? exp_load(op, addr[1:0], rdata) : alu;
        ew.stall = (mem && !mis) ? 8'(2 + gdly + (ld ? rdly : 0)) : 8'd0;
        ew.reqs  = (mem && !mis) ? 8'(gdly + 1) : 8'd0;
        ew.excp  = mis;
        wb_q.push_back(ew);

        mem_mem_aluop  = op;
        mem_mem_addr   = addr;
        mem_rt_data    = rt;
        mem_wdata      = alu;
        mem_waddr      = wa;
        mem_we         = we;
        dmem_bus.rdata = rdata;
        dmem_bus.gnt   = 1'b0;
        dmem_bus.rvalid = 1'b0;
        eb = '0;
        req_seen = 0; since = 0; stall_n = 0; granted = 1'b0; done = 1'b0;
        #1;
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            if (stall_req) stall_n++;
            if (dmem_bus.req) begin
                req_seen++;
                if (req_seen == 1 && bus_q.size() != 0) eb = bus_q.pop_front();
                check({tag, "_addr"}, dmem_bus.addr, eb.addr);
                check({tag, "_we"}, 32'(dmem_bus.we), 32'(eb.we));
                if (eb.we) begin
                    check({tag, "_be"}, 32'(dmem_bus.be), 32'(eb.be));
                    check({tag, "_wdata"}, dmem_bus.wdata, eb.wdata);
                end
                dmem_bus.gnt    = req_seen > gdly;
                dmem_bus.rvalid = dmem_bus.gnt && ld && rdly == 0;
                if (dmem_bus.gnt) granted = 1'b1;
            end else begin
                dmem_bus.gnt = 1'b0;
                if (granted && ld) begin
                    since++;
                    dmem_bus.rvalid = since == rdly;
                end else begin
                    dmem_bus.rvalid = 1'b0;
                end
            end
            if (!stall_req) begin
                done = 1'b1;
                dmem_bus.gnt    = 1'b0;
                dmem_bus.rvalid = 1'b0;
                if (wb_q.size() != 0) begin
                    gw = wb_q.pop_front();
                    check({tag, "_wb_we"}, 32'(wb_we), 32'(gw.we));
                    check({tag, "_wb_waddr"}, 32'(wb_waddr), 32'(gw.waddr));
                    if (gw.we) check({tag, "_wb_wdata"}, wb_wdata, gw.wdata);
                    check({tag, "_stall_cycles"}, 32'(stall_n), 32'(gw.stall));
                    check({tag, "_req_cycles"}, 32'(req_seen), 32'(gw.reqs));
`ifdef MEM_MISALIGN_TRAP_EN
                    check({tag, "_excp"}, 32'(excp_misalign), 32'(gw.excp));
`endif
                end
            end else begin
                @(negedge clk);
                #1;
            end
        end
        check({tag, "_completed"}, 32'(done), 32'd1);
        @(negedge clk);
        #1;
    endtask

    logic [7:0] ops [9];

    initial begin
        n_chk = 0;
        n_pass = 0;
        ops = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW, OP_ADD_TB};
        rst_n = 1'b0;
        dmem_bus.gnt = 1'b0;
        dmem_bus.rvalid = 1'b0;
        dmem_bus.rdata = '0;
        mem_mem_aluop = OP_ADD_TB;
        mem_we = 1'b1;
        mem_waddr = 5'd7;
        mem_wdata = 32'hFFFF_FFFF;
        mem_mem_addr = 32'h0;
        mem_rt_data = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req", 32'(dmem_bus.req), 32'd0);
        check("rst_stall", 32'(stall_req), 32'd0);
        check("rst_wb_we", 32'(wb_we), 32'd0);
        check("rst_wb_wdata", wb_wdata, 32'd0);
        check("rst_dmem_addr", dmem_bus.addr, 32'd0);
        check("rst_dmem_be", 32'(dmem_bus.be), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        #1;

        run_op("add",    OP_ADD_TB, 32'h0,   32'h0,         32'h1234_5678, 5'd5,  1'b1, 0, 0, 32'h0);
        run_op("sb",     OP_SB,     32'h103, 32'hAABB_CCDD, 32'h103,       5'd9,  1'b1, 2, 0, 32'h0);
        run_op("lb",     OP_LB,     32'h201, 32'h0,         32'h201,       5'd3,  1'b1, 0, 1, 32'h0000_800F);
        run_op("lbu",    OP_LBU,    32'h201, 32'h0,         32'h201,       5'd3,  1'b1, 0, 1, 32'h0000_800F);
        run_op("lh",     OP_LH,     32'h302, 32'h0,         32'h302,       5'd4,  1'b1, 0, 0, 32'h8001_0000);
        run_op("sh",     OP_SH,     32'h106, 32'h1122_3344, 32'h106,       5'd8,  1'b1, 1, 0, 32'h0);
        run_op("sw",     OP_SW,     32'h108, 32'hCAFE_F00D, 32'h108,       5'd10, 1'b1, 0, 0, 32'h0);
        run_op("lhu",    OP_LHU,    32'h300, 32'h0,         32'h300,       5'd11, 1'b1, 1, 3, 32'h1234_ABCD);
        run_op("lw_mis", OP_LW,     32'h402, 32'h0,         32'h402,       5'd12, 1'b1, 0, 0, 32'h5566_7788);
        run_op("sw_mis", OP_SW,     32'h40A, 32'h0BAD_F00D, 32'h40A,       5'd13, 1'b1, 0, 0, 32'h0);

        // Reset while waiting for rvalid, then a stray rvalid after release
        mem_mem_aluop = OP_LW;
        mem_mem_addr = 32'h500;
        mem_we = 1'b1;
        mem_waddr = 5'd6;
        mem_wdata = 32'h500;
        dmem_bus.rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        #1;
        check("rstw_req", 32'(dmem_bus.req), 32'd1);
        check("rstw_addr", dmem_bus.addr, 32'h500);
        dmem_bus.gnt = 1'b1;
        @(negedge clk);
        #1;
        dmem_bus.gnt = 1'b0;
        check("rstw_in_wait", 32'(dut.state), 32'(ST_WAIT));
        check("rstw_stall", 32'(stall_req), 32'd1);
        rst_n = 1'b0;
        mem_mem_aluop = OP_ADD_TB;
        mem_we = 1'b0;
        mem_wdata = 32'h0;
        #1;
        check("rstw_state", 32'(dut.state), 32'(ST_IDLE));
        check("rstw_req_low", 32'(dmem_bus.req), 32'd0);
        check("rstw_stall_low", 32'(stall_req), 32'd0);
        check("rstw_wb_we", 32'(wb_we), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        dmem_bus.rvalid = 1'b1;
        @(negedge clk);
        #1;
        dmem_bus.rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("late_rv_state", 32'(dut.state), 32'(ST_IDLE));
            check("late_rv_wb_we", 32'(wb_we), 32'd0);
            check("late_rv_wb_wdata", wb_wdata, 32'd0);
            check("late_rv_req", 32'(dmem_bus.req), 32'd0);
            @(negedge clk);
            #1;
        end

        for (int i = 0; i < 24; i++) begin
            run_op("rnd", ops[$urandom_range(0, 8)], 32'h1000 + 32'($urandom_range(0, 255)),
                   $urandom, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
        end

        check("wb_q_empty", 32'(wb_q.size()), 32'd0);
        check("bus_q_empty", 32'(bus_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
